add_result_checker: RTL and testbench

//  Post-run checker for the adder test system. After a run, it walks the result RAM and a golden-result
//  RAM in lock-step over the Avalon-side clock domain and compares each word under a bit mask.
//  It counts mismatches and records the first failing address, so software reads one status

---
 rtl/add_result_checker_if.sv | 33 +++
 rtl/add_result_checker.sv | 150 +++++++++++++++
 tb/tb_add_result_checker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_result_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : add_result_checker_if                                  |
// | Description : Shared read bus between the result checker and the     |
// |               result/golden RAM pair (one address, two data words).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface add_result_checker_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] q_result;
  logic [DATA_WIDTH-1:0] q_golden;

  // Checker side: issues reads, consumes both data words
  modport master (
    output rd_en,
    output rd_addr,
    input  q_result,
    input  q_golden
  );

  // RAM side: answers reads READ_LAT cycles later
  modport slave (
    input  rd_en,
    input  rd_addr,
    output q_result,
    output q_golden
  );
endinterface
`default_nettype wire

// File: rtl/add_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : add_result_checker                                     |
// | Description : Walks the result and golden RAMs in lock-step, compares|
// |               each word under a mask, counts mismatches (saturating) |
// |               and records the first failing address.                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module add_result_checker #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1,
  parameter int ERR_WIDTH  = 16
) (
  input  wire                   avalon_clock,
  input  wire                   resetn,
  input  wire                   start,
  input  wire                   abort,
  input  wire  [ADDR_WIDTH:0]   num_vectors,
  input  wire  [DATA_WIDTH-1:0] mask,
  add_result_checker_if.master  ram,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // All stages except the oldest; when these are empty the oldest entry is
  // being compared on this edge, so the run ends here.
  localparam logic [READ_LAT-1:0]  EARLY_STAGE_MASK = {READ_LAT{1'b1}} >> 1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX          = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [READ_LAT-1:0]   pipe_vld;
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LAT];

  logic                  mismatch;
  logic                  drained;
  logic [ADDR_WIDTH:0]   num_m1;

  // Oldest pipeline stage lines up with the RAM data currently on q
  assign mismatch = pipe_vld[READ_LAT-1] &&
                    (|((ram.q_result ^ ram.q_golden) & mask_q));
  assign drained  = ((pipe_vld & EARLY_STAGE_MASK) == '0);
  // Truncation of (num_vectors-1) gives the last address; for the full depth
  // this is all-ones, so the address counter never wraps.
  assign num_m1   = num_vectors - 1'b1;

  // {valid,addr} delay line matching the RAM read latency; abort flushes it
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr[i] <= '0;
    end else if (abort) begin
      pipe_vld <= '0;
    end else begin
      for (int i = READ_LAT-1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      pipe_vld[0]  <= ram.rd_en;
      pipe_addr[0] <= ram.rd_addr;
    end
  end

  // Control FSM with registered outputs plus the mismatch accumulator
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      ram.rd_en       <= 1'b0;
      ram.rd_addr     <= '0;
      last_addr       <= '0;
      mask_q          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (abort) begin
      // Partial error results are kept for software to inspect
      state     <= S_IDLE;
      ram.rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= pipe_addr[READ_LAT-1];
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          // Pipeline is empty here, so clearing cannot race a compare
          if (start) begin
            mask_q          <= mask;
            last_addr       <= num_m1[ADDR_WIDTH-1:0];
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            ram.rd_addr     <= '0;
            if (num_vectors == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= S_ISSUE;
              ram.rd_en <= 1'b1;
              done      <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (ram.rd_addr == last_addr) begin
            ram.rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            ram.rd_addr <= ram.rd_addr + 1'b1;
          end
        end

        S_DRAIN: begin
          if (drained) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_add_result_checker                                  |
// | Description : Bench for add_result_checker. Three instances run side |
// |               by side: (READ_LAT=1,ERR=16), (1,4), (3,4).            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_add_result_checker;
  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int NDUT = 3;

  typedef struct {
    int err;
    int fv;
    int fa;
    int done_cyc;
  } exp_t;

  logic          clk         = 1'b0;
  logic          resetn      = 1'b0;
  logic          start       = 1'b0;
  logic          abort       = 1'b0;
  logic [AW:0]   num_vectors = '0;
  logic [DW-1:0] mask        = '0;

  logic [DW-1:0] res_mem  [2**AW];
  logic [DW-1:0] gold_mem [2**AW];

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string tname  = "reset";

  always #5 clk = ~clk;

  add_result_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  add_result_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  add_result_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

  logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic          fv_a, fv_b, fv_c;
  logic [15:0]   err_a;
  logic [3:0]    err_b, err_c;
  logic [AW-1:0] fa_a, fa_b, fa_c;

  add_result_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .ERR_WIDTH(16)) dut_a (
    .avalon_clock(clk), .resetn(resetn), .start(start), .abort(abort),
    .num_vectors(num_vectors), .mask(mask), .ram(bus_a),
    .busy(busy_a), .done(done_a), .err_count(err_a),
    .first_err_valid(fv_a), .first_err_addr(fa_a));

  add_result_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .ERR_WIDTH(4)) dut_b (
    .avalon_clock(clk), .resetn(resetn), .start(start), .abort(abort),
    .num_vectors(num_vectors), .mask(mask), .ram(bus_b),
    .busy(busy_b), .done(done_b), .err_count(err_b),
    .first_err_valid(fv_b), .first_err_addr(fa_b));

  add_result_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(3), .ERR_WIDTH(4)) dut_c (
    .avalon_clock(clk), .resetn(resetn), .start(start), .abort(abort),
    .num_vectors(num_vectors), .mask(mask), .ram(bus_c),
    .busy(busy_c), .done(done_c), .err_count(err_c),
    .first_err_valid(fv_c), .first_err_addr(fa_c));

  // Uniform views of the three instances
  logic          busy_v [NDUT];
  logic          done_v [NDUT];
  logic          fv_v   [NDUT];
  logic          rd_v   [NDUT];
  logic [15:0]   err_v  [NDUT];
  logic [AW-1:0] fa_v   [NDUT];
  logic [AW-1:0] addr_v [NDUT];

  assign busy_v[0] = busy_a;        assign busy_v[1] = busy_b;        assign busy_v[2] = busy_c;
  assign done_v[0] = done_a;        assign done_v[1] = done_b;        assign done_v[2] = done_c;
  assign fv_v[0]   = fv_a;          assign fv_v[1]   = fv_b;          assign fv_v[2]   = fv_c;
  assign err_v[0]  = err_a;         assign err_v[1]  = {12'd0, err_b}; assign err_v[2] = {12'd0, err_c};
  assign fa_v[0]   = fa_a;          assign fa_v[1]   = fa_b;          assign fa_v[2]   = fa_c;
  assign rd_v[0]   = bus_a.rd_en;   assign rd_v[1]   = bus_b.rd_en;   assign rd_v[2]   = bus_c.rd_en;
  assign addr_v[0] = bus_a.rd_addr; assign addr_v[1] = bus_b.rd_addr; assign addr_v[2] = bus_c.rd_addr;

  // RAM models: latency 1 for a/b, latency 3 for c
  logic [DW-1:0] c_res_d  [2];
  logic [DW-1:0] c_gold_d [2];
  always @(posedge clk) begin
    bus_a.q_result <= res_mem[bus_a.rd_addr];
    bus_a.q_golden <= gold_mem[bus_a.rd_addr];
    bus_b.q_result <= res_mem[bus_b.rd_addr];
    bus_b.q_golden <= gold_mem[bus_b.rd_addr];
    c_res_d[0]     <= res_mem[bus_c.rd_addr];
    c_gold_d[0]    <= gold_mem[bus_c.rd_addr];
    c_res_d[1]     <= c_res_d[0];
    c_gold_d[1]    <= c_gold_d[0];
    bus_c.q_result <= c_res_d[1];
    bus_c.q_golden <= c_gold_d[1];
  end

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s dut%0d observed=%0d expected=%0d", tname, tag, d, obs, exp);
    end
  endtask

  // Reference behaviour of one instance for a complete run
  function automatic exp_t model(input int d, input int n, input logic [DW-1:0] m);
    exp_t e;
    int   sat;
    int   lat;
    sat = (d == 0) ? 65535 : 15;
    lat = (d == 2) ? 3 : 1;
    e.err = 0; e.fv = 0; e.fa = 0;
    for (int a = 0; a < n; a++) begin
      if (((res_mem[a] ^ gold_mem[a]) & m) != '0) begin
        if (e.err < sat) e.err++;
        if (e.fv == 0) begin
          e.fv = 1;
          e.fa = a;
        end
      end
    end
    e.done_cyc = (n == 0) ? 1 : n + lat + 1;
    return e;
  endfunction

  // One complete run; an optional start pulse lands mid-run in cycle glitch_cyc
  task automatic do_run(input int n, input logic [DW-1:0] m, input int glitch_cyc);
    int   done_at [NDUT];
    int   rd_cnt  [NDUT];
    int   last_a  [NDUT];
    logic busy1   [NDUT];
    int   c;
    bit   all_done;
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      sb.push_back(model(d, n, m));
      done_at[d] = -1; rd_cnt[d] = 0; last_a[d] = -1; busy1[d] = 1'b0;
    end
    @(negedge clk);
    num_vectors = (AW+1)'(n);
    mask        = m;
    start       = 1'b1;
    @(posedge clk);          // edge 0
    #1 start = 1'b0;
    c = 1;
    all_done = 1'b0;
    while (!all_done && c <= n + 16) begin
      all_done = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        if (c == 1) busy1[d] = busy_v[d];
        if (rd_v[d] === 1'b1) begin
          rd_cnt[d]++;
          last_a[d] = int'(addr_v[d]);
        end
        if (done_at[d] < 0 && done_v[d] === 1'b1) done_at[d] = c;
        if (done_at[d] < 0) all_done = 1'b0;
      end
      if (c == glitch_cyc) begin
        start       = 1'b1;
        num_vectors = (AW+1)'(2);
        mask        = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 c++;
    end
    start = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      e = sb.pop_front();
      check("done_cycle", d, done_at[d], e.done_cyc);
      check("err_count", d, err_v[d], e.err);
      check("first_valid", d, {31'd0, fv_v[d]}, e.fv);
      check("first_addr", d, {21'd0, fa_v[d]}, e.fa);
      check("busy_cyc1", d, {31'd0, busy1[d]}, (n > 0) ? 1 : 0);
      check("busy_end", d, {31'd0, busy_v[d]}, 0);
      check("reads", d, rd_cnt[d], n);
      check("last_addr", d, last_a[d], (n > 0) ? n - 1 : -1);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check({tag, "_rd_en"}, d, {31'd0, rd_v[d]}, 0);
      check({tag, "_busy"}, d, {31'd0, busy_v[d]}, 0);
      check({tag, "_done"}, d, {31'd0, done_v[d]}, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      gold_mem[a] = $urandom;
      res_mem[a]  = gold_mem[a];
    end

    // Reset state
    #12;
    check_idle("rst");
    for (int d = 0; d < NDUT; d++) begin
      check("rst_err", d, err_v[d], 0);
      check("rst_fv", d, {31'd0, fv_v[d]}, 0);
      check("rst_fa", d, {21'd0, fa_v[d]}, 0);
    end
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    // All words match; a stray start in cycle 3 must not disturb the run
    tname = "match";
    do_run(8, '1, 3);

    // Bit-0 errors at addresses 3 and 6
    tname = "errors";
    res_mem[3] ^= 32'h1;
    res_mem[6] ^= 32'h1;
    do_run(8, '1, 0);

    // Restart from DONE: only this run's single error is reported
    tname = "restart";
    res_mem[3] ^= 32'h1;
    res_mem[6] ^= 32'h1;
    res_mem[5] ^= 32'h100;
    do_run(8, '1, 0);

    // Same data as the error run, masked bit 0
    tname = "mask";
    res_mem[5] ^= 32'h100;
    res_mem[3] ^= 32'h1;
    res_mem[6] ^= 32'h1;
    do_run(8, 32'hFFFF_FFFE, 0);

    tname = "zero_len";
    do_run(0, '1, 0);

    // Full depth, every word differs: saturation on the 4-bit instances
    tname = "full";
    for (int a = 0; a < 2**AW; a++) res_mem[a] = ~gold_mem[a];
    do_run(2**AW, '1, 0);

    // Abort at cycle 5 of a 100-word run; errors at addresses 0 and 2
    tname = "abort";
    for (int a = 0; a < 2**AW; a++) res_mem[a] = gold_mem[a];
    res_mem[0] ^= 32'h20;
    res_mem[2] ^= 32'h1;
    @(negedge clk);
    num_vectors = (AW+1)'(100);
    mask = '1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_idle("abort");
    repeat (5) @(posedge clk);
    #1;
    check_idle("abort_late");
    for (int d = 0; d < NDUT; d++) begin
      check("abort_err", d, err_v[d], (d == 2) ? 1 : 2);
      check("abort_fv", d, {31'd0, fv_v[d]}, 1);
      check("abort_fa", d, {21'd0, fa_v[d]}, 0);
    end

    // start and abort together: abort wins, partial results not cleared
    tname = "abort_start";
    @(negedge clk);
    num_vectors = (AW+1)'(8);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check_idle("as");
    repeat (3) @(posedge clk);
    #1;
    check_idle("as_late");
    for (int d = 0; d < NDUT; d++) check("as_err", d, err_v[d], (d == 2) ? 1 : 2);

    // Asynchronous reset mid-run
    tname = "reset_mid";
    for (int a = 0; a < 2**AW; a++) res_mem[a] = ~gold_mem[a];
    @(negedge clk);
    num_vectors = (AW+1)'(100);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_err", 0, err_v[0], 2);
    check("pre_busy", 0, {31'd0, busy_v[0]}, 1);
    #1 resetn = 1'b0;
    #1;
    check_idle("rmid");
    for (int d = 0; d < NDUT; d++) begin
      check("rmid_err", d, err_v[d], 0);
      check("rmid_fv", d, {31'd0, fv_v[d]}, 0);
      check("rmid_fa", d, {21'd0, fa_v[d]}, 0);
      check("rmid_addr", d, {21'd0, addr_v[d]}, 0);
    end
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("post_rst");
    check("sb_empty", 0, sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
